// File: rtl/bin2bcd_serial_if.sv
// Handshake/result bundle for the serial binary-to-BCD converter.
// Master drives start/binary; slave returns busy/done/bcd/ovf.
interface bin2bcd_serial_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      binary;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (output start, binary, input  busy, done, bcd, ovf);
  modport slave  (input  start, binary, output busy, done, bcd, ovf);
endinterface

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter, one operand bit per clock.
// Result and overflow are registered on completion and held until the next one.
module bin2bcd_serial #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  bin2bcd_serial_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [BCD_W-1:0]   corr;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               acc_q, acc_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    // All digits are corrected from their pre-shift values in parallel.
    corr = work_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5)
        corr[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          opnd_d  = bus.binary;
          work_d  = '0;
          acc_d   = 1'b0;
          cnt_d   = CNT_W'(WIDTH);
        end
      end
      SHIFT: begin
        // The top digit's bit 3 falls off the end; catching it flags overflow.
        work_d = {corr[BCD_W-2:0], opnd_q[WIDTH-1]};
        opnd_d = opnd_q << 1;
        acc_d  = acc_q | corr[BCD_W-1];
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          bcd_d   = work_d;
          ovf_d   = acc_d;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;
endmodule
